dog_stream_arbiter: RTL and testbench
=====================================

Name: dog_stream_arbiter

Overview:
- Merges the four difference-of-Gaussian pixel streams (d0..d3) from one octave onto a single tagged output stream with valid/ready handshake.
- Feeds the downstream extrema/keypoint stage or frame writer, which accepts at most one pixel per cycle.
- Each channel has a small FIFO. Channels are served round-robin. Per-channel order is preserved, and overflow is reported per channel and sticky.

Parameters:
- DEPTH, 16, entries per channel FIFO; power of two, minimum 2.
- DW, 8, pixel data width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- d0_dout  in  DW  channel 0 pixel.
- d0_valid  in  1  channel 0 pixel present this cycle.
- d1_dout, d1_valid, d2_dout, d2_valid, d3_dout, d3_valid  in  DW/1 each  channels 1..3, same meaning as channel 0.
- out_data  out  DW  granted pixel.
- out_chan  out  2  source channel of out_data.
- out_valid  out  1  out_data/out_chan hold a pixel.
- out_ready  in  1  downstream accepts the pixel this cycle.
- clear_overflow  in  1  one-cycle pulse that clears all overflow flags.
- overflow  out  4  sticky per-channel drop flags.
- busy  out  1  any FIFO non-empty or out_valid high.

Behaviour:
- Reset: all FIFOs empty; out_valid=0, out_data=0, out_chan=0, overflow=0, busy=0; round-robin pointer=3, so channel 0 has first priority.
- Reset mid-operation discards all buffered and in-flight pixels. Inputs are ignored in the reset cycle.
- Push: dN_valid=1 writes dN_dout into FIFO N at the clock edge. All four channels may push in the same cycle.
- Full handling: if FIFO N is full and is not popped in the same cycle, the pixel is dropped and overflow[N] is set.
  - Push to a full FIFO that is popped in the same cycle is accepted; the count stays DEPTH.
- Output register load: the output register loads when (out_valid==0 || out_ready==1) and at least one FIFO is non-empty.
  - Grant goes to the first non-empty channel in order ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - The granted FIFO pops, out_data/out_chan take its head, out_valid=1, and ptr becomes the granted channel.
  - If no FIFO is non-empty and out_ready=1, out_valid drops to 0.
- Stalls: while out_valid=1 and out_ready=0, out_data, out_chan and out_valid hold stable, and no pop occurs.
- Latency: a pixel pushed at edge k into an empty system, with out_valid=0, appears with out_valid=1 after edge k+1.
  - No combinational path from inputs to outputs.
- Throughput: one pixel per cycle when out_ready is held high.
- Fairness: with all channels continuously non-empty, grants cycle 0,1,2,3,0,…
- FIFO bypass: pop and push on the same FIFO in the same cycle are both honoured. An empty FIFO is never bypassed; the pushed pixel becomes visible next cycle.
- Overflow flags: overflow[N] stays set until clear_overflow. If clear_overflow and a new drop on N occur in the same cycle, the set wins.
- busy is registered-equivalent: derived from FIFO counts and out_valid, no input terms.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.

Decomposition:
- Shared package holds:
  - DOG_CHANNELS=4;
  - channel id typedef (2 bits);
  - the default DW=8 constant, matching the Gaussian/DoG pixel width.
- One sub-module, dog_chan_fifo: synchronous single-clock FIFO with push, pop, full, empty and a head output that is valid when non-empty.
  - The top instantiates four of them, plus the round-robin grant logic and the output register.

Test Plan:
- Single pixel: reset, then d2_valid=1 with d2_dout=0x5A for one cycle, out_ready=1. Required: out_valid=1 with out_data=0x5A and out_chan=2 exactly two edges after the push cycle starts; busy falls after acceptance.
- Simultaneous push: all four channels valid for one cycle with data 0x10,0x21,0x32,0x43, out_ready=1. Required: outputs in order chan 0,1,2,3 on consecutive cycles with the matching data; no overflow.
- Backpressure: load 3 pixels into channel 1, hold out_ready=0 for 10 cycles, then raise it. Required: first pixel stable for the whole stall, then all 3 pixels in order; no loss.
- Overflow: out_ready=0, push DEPTH+2 pixels into channel 3. Required: overflow=4'b1000; the first DEPTH pixels drain intact; clear_overflow pulse clears it. A drop in the same cycle as clear leaves the flag set.
- Fairness under load: all four channels valid every cycle for 64 cycles, out_ready=1. Required: out_chan sequence 0,1,2,3 repeating; every overflow bit set once the FIFOs fill.
- Reset mid-stream: with FIFOs half full and out_valid=1, assert reset for one cycle. Required: out_valid=0, busy=0, overflow=0 next cycle; first grant afterwards goes to channel 0.

Source files
------------

// File: rtl/dog_stream_arbiter_pkg.sv
// Shared definitions for the DoG stream arbiter slice.
//   DOG_CHANNELS : number of difference-of-Gaussian streams per octave
//   dog_chan_t   : channel identifier carried alongside each output pixel
//   DOG_DW       : default pixel width, matching the Gaussian/DoG datapath
package dog_stream_arbiter_pkg;

    localparam int unsigned DOG_CHANNELS = 4;
    localparam int unsigned DOG_DW       = 8;

    typedef logic [1:0] dog_chan_t;

endpackage

// File: rtl/dog_chan_fifo.sv
// Single-clock synchronous FIFO for one DoG channel.
// Ports:
//   clock, reset   : system clock, synchronous active-high reset
//   push/push_data : write request and pixel; accepted if not full or popped this cycle
//   pop            : read request; ignored when empty
//   head           : oldest entry, valid while empty is low
//   full, empty    : occupancy status derived from the registered count
module dog_chan_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // A full FIFO still takes a push when its head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage needs no reset; pointers and count define what is live.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/dog_stream_arbiter.sv
// Merges the four DoG pixel streams of one octave onto one tagged valid/ready stream.
// Ports:
//   clock, reset           : system clock, synchronous active-high reset
//   dN_dout, dN_valid      : per-channel pixel input, pushed into FIFO N when valid
//   out_data, out_chan     : registered granted pixel and its source channel
//   out_valid, out_ready   : output handshake
//   clear_overflow         : pulse clearing all sticky overflow flags
//   overflow               : sticky per-channel drop flags
//   busy                   : any FIFO holds data or the output register is occupied
module dog_stream_arbiter
    import dog_stream_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = DOG_DW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [DW-1:0] d0_dout,
    input  logic          d0_valid,
    input  logic [DW-1:0] d1_dout,
    input  logic          d1_valid,
    input  logic [DW-1:0] d2_dout,
    input  logic          d2_valid,
    input  logic [DW-1:0] d3_dout,
    input  logic          d3_valid,
    output logic [DW-1:0] out_data,
    output dog_chan_t     out_chan,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic          clear_overflow,
    output logic [3:0]    overflow,
    output logic          busy
);

    logic [DW-1:0]           din [DOG_CHANNELS];
    logic [DOG_CHANNELS-1:0] din_valid;
    logic [DW-1:0]           fifo_head [DOG_CHANNELS];
    logic [DOG_CHANNELS-1:0] fifo_full;
    logic [DOG_CHANNELS-1:0] fifo_empty;
    logic [DOG_CHANNELS-1:0] fifo_pop;
    logic [DOG_CHANNELS-1:0] drop;

    logic [DW-1:0] out_data_q;
    dog_chan_t     out_chan_q;
    logic          out_valid_q;
    dog_chan_t     ptr_q;
    logic [3:0]    overflow_q;

    dog_chan_t grant_chan;
    dog_chan_t cand;
    logic      grant_valid;
    logic      load;

    assign din[0] = d0_dout;
    assign din[1] = d1_dout;
    assign din[2] = d2_dout;
    assign din[3] = d3_dout;
    assign din_valid = {d3_valid, d2_valid, d1_valid, d0_valid};

    for (genvar n = 0; n < DOG_CHANNELS; n++) begin : g_chan
        assign fifo_pop[n] = load && (grant_chan == dog_chan_t'(n));
        assign drop[n]     = din_valid[n] && fifo_full[n] && !fifo_pop[n];

        dog_chan_fifo #(
            .DEPTH (DEPTH),
            .DW    (DW)
        ) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .push      (din_valid[n]),
            .push_data (din[n]),
            .pop       (fifo_pop[n]),
            .head      (fifo_head[n]),
            .full      (fifo_full[n]),
            .empty     (fifo_empty[n])
        );
    end

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        grant_valid = 1'b0;
        grant_chan  = ptr_q;
        cand        = '0;
        for (int i = 1; i <= DOG_CHANNELS; i++) begin
            cand = ptr_q + dog_chan_t'(i);
            if (!grant_valid && !fifo_empty[cand]) begin
                grant_valid = 1'b1;
                grant_chan  = cand;
            end
        end
    end

    assign load = (!out_valid_q || out_ready) && grant_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= dog_chan_t'(DOG_CHANNELS - 1);
            overflow_q  <= '0;
        end else begin
            if (load) begin
                out_data_q  <= fifo_head[grant_chan];
                out_chan_q  <= grant_chan;
                out_valid_q <= 1'b1;
                ptr_q       <= grant_chan;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            // A new drop wins over a simultaneous clear.
            overflow_q <= (overflow_q & ~{4{clear_overflow}}) | drop;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
    assign busy      = out_valid_q || !(&fifo_empty);

endmodule

// File: tb/tb_dog_stream_arbiter.sv
module tb_dog_stream_arbiter;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned DW    = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] d0_dout, d1_dout, d2_dout, d3_dout;
    logic          d0_valid, d1_valid, d2_valid, d3_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_chan;
    logic          out_valid;
    logic          out_ready;
    logic          clear_overflow;
    logic [3:0]    overflow;
    logic          busy;

    int errors = 0;
    int checks = 0;

    dog_stream_arbiter #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .d0_dout        (d0_dout),
        .d0_valid       (d0_valid),
        .d1_dout        (d1_dout),
        .d1_valid       (d1_valid),
        .d2_dout        (d2_dout),
        .d2_valid       (d2_valid),
        .d3_dout        (d3_dout),
        .d3_valid       (d3_valid),
        .out_data       (out_data),
        .out_chan       (out_chan),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .clear_overflow (clear_overflow),
        .overflow       (overflow),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Advance one edge; sample and drive 1 time unit after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        d0_valid = 0; d1_valid = 0; d2_valid = 0; d3_valid = 0;
        d0_dout = '0; d1_dout = '0; d2_dout = '0; d3_dout = '0;
        clear_overflow = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        out_ready = 1;
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        out_ready = 0;
        reset = 1;
        step();
        step();
        reset = 0;
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid got=%b want=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++;
            $display("FAIL reset_data got=%h want=00", out_data); end
        checks++; if (out_chan !== 2'd0) begin errors++;
            $display("FAIL reset_chan got=%0d want=0", out_chan); end
        checks++; if (overflow !== 4'b0000) begin errors++;
            $display("FAIL reset_overflow got=%b want=0000", overflow); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy got=%b want=0", busy); end
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1;
        d2_valid = 1; d2_dout = 8'h5A;
        step();
        d2_valid = 0;
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL single_early got=%b want=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A || out_chan !== 2'd2) begin
            errors++;
            $display("FAIL single_out got v=%b d=%h c=%0d want v=1 d=5a c=2",
                     out_valid, out_data, out_chan); end
        checks++; if (busy !== 1'b1) begin errors++;
            $display("FAIL single_busy got=%b want=1", busy); end
        step();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL single_drain got v=%b busy=%b want 0 0", out_valid, busy); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp_data [4];
        exp_data[0] = 8'h10; exp_data[1] = 8'h21; exp_data[2] = 8'h32; exp_data[3] = 8'h43;
        do_reset();
        out_ready = 1;
        d0_valid = 1; d1_valid = 1; d2_valid = 1; d3_valid = 1;
        d0_dout = 8'h10; d1_dout = 8'h21; d2_dout = 8'h32; d3_dout = 8'h43;
        step();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (out_valid !== 1'b1 || out_chan !== 2'(i) || out_data !== exp_data[i])
            begin
                errors++;
                $display("FAIL simul_%0d got v=%b c=%0d d=%h want v=1 c=%0d d=%h",
                         i, out_valid, out_chan, out_data, i, exp_data[i]);
            end
        end
        step();
        checks++; if (out_valid !== 1'b0 || overflow !== 4'b0000) begin errors++;
            $display("FAIL simul_end got v=%b ovf=%b want v=0 ovf=0000", out_valid, overflow); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 0;
        d1_valid = 1;
        d1_dout = 8'hA1; step();
        d1_dout = 8'hA2; step();
        d1_dout = 8'hA3; step();
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (out_valid !== 1'b1 || out_data !== 8'hA1 || out_chan !== 2'd1) begin
                errors++;
                $display("FAIL stall_%0d got v=%b d=%h c=%0d want v=1 d=a1 c=1",
                         i, out_valid, out_data, out_chan);
            end
        end
        out_ready = 1;
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA2) begin errors++;
            $display("FAIL bp_second got v=%b d=%h want v=1 d=a2", out_valid, out_data); end
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA3) begin errors++;
            $display("FAIL bp_third got v=%b d=%h want v=1 d=a3", out_valid, out_data); end
        step();
        checks++; if (out_valid !== 1'b0 || overflow !== 4'b0000) begin errors++;
            $display("FAIL bp_end got v=%b ovf=%b want v=0 ovf=0000", out_valid, overflow); end
    endtask

    // Pushes DEPTH+2 pixels into channel 3 with out_ready low. The output register
    // holds pixel 0 and the FIFO holds 1..DEPTH, so exactly the last push drops.
    task automatic fill_ch3(input logic clear_on_last);
        out_ready = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            d3_valid = 1;
            d3_dout = 8'(i);
            clear_overflow = clear_on_last && (i == DEPTH + 1);
            step();
        end
        idle_inputs();
    endtask

    task automatic test_overflow();
        do_reset();
        fill_ch3(1'b0);
        checks++; if (overflow !== 4'b1000) begin errors++;
            $display("FAIL ovf_set got=%b want=1000", overflow); end
        out_ready = 1;
        for (int i = 0; i <= DEPTH; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 8'(i) || out_chan !== 2'd3) begin
                errors++;
                $display("FAIL ovf_drain_%0d got v=%b d=%h c=%0d want v=1 d=%h c=3",
                         i, out_valid, out_data, out_chan, 8'(i));
            end
            step();
        end
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL ovf_extra got v=%b want 0", out_valid); end
        checks++; if (overflow !== 4'b1000) begin errors++;
            $display("FAIL ovf_sticky got=%b want=1000", overflow); end
        clear_overflow = 1;
        step();
        clear_overflow = 0;
        checks++; if (overflow !== 4'b0000) begin errors++;
            $display("FAIL ovf_clear got=%b want=0000", overflow); end
        fill_ch3(1'b1);
        checks++; if (overflow !== 4'b1000) begin errors++;
            $display("FAIL ovf_set_wins got=%b want=1000", overflow); end
    endtask

    task automatic test_fairness();
        int m;
        m = 0;
        do_reset();
        out_ready = 1;
        for (int j = 0; j < 64; j++) begin
            d0_valid = 1; d1_valid = 1; d2_valid = 1; d3_valid = 1;
            d0_dout = 8'(0 * 64 + j);
            d1_dout = 8'(1 * 64 + j);
            d2_dout = 8'(2 * 64 + j);
            d3_dout = 8'(3 * 64 + j);
            step();
            if (out_valid === 1'b1) begin
                checks++; if (out_chan !== 2'(m % 4) || out_data !== 8'((m % 4) * 64 + m / 4))
                begin
                    errors++;
                    $display("FAIL fair_%0d got c=%0d d=%h want c=%0d d=%h", m, out_chan,
                             out_data, m % 4, 8'((m % 4) * 64 + m / 4));
                end
                m++;
            end
        end
        idle_inputs();
        checks++; if (m != 63) begin errors++;
            $display("FAIL fair_count got=%0d want=63", m); end
        checks++; if (overflow !== 4'b1111) begin errors++;
            $display("FAIL fair_overflow got=%b want=1111", overflow); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 0;
        for (int i = 0; i < 20; i++) begin
            d1_valid = 1; d1_dout = 8'(i);
            d0_valid = (i < 8); d0_dout = 8'(i);
            d2_valid = (i < 8); d2_dout = 8'(i);
            d3_valid = (i < 8); d3_dout = 8'(i);
            step();
        end
        idle_inputs();
        checks++; if (out_valid !== 1'b1 || overflow !== 4'b0010) begin errors++;
            $display("FAIL mid_pre got v=%b ovf=%b want v=1 ovf=0010", out_valid, overflow); end
        // Inputs during the reset cycle must be ignored.
        reset = 1;
        d0_valid = 1; d1_valid = 1; d2_valid = 1; d3_valid = 1;
        step();
        reset = 0;
        idle_inputs();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || overflow !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset got v=%b busy=%b ovf=%b want 0 0 0000",
                     out_valid, busy, overflow); end
        out_ready = 1;
        d3_valid = 1; d3_dout = 8'hC3;
        d0_valid = 1; d0_dout = 8'hC0;
        step();
        idle_inputs();
        step();
        checks++; if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 8'hC0) begin
            errors++;
            $display("FAIL mid_first got v=%b c=%0d d=%h want v=1 c=0 d=c0",
                     out_valid, out_chan, out_data); end
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        out_ready = 0;
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_overflow();
        test_fairness();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
